key_checker_param: RTL and testbench
====================================

// Module: key_checker_param
// PURPOSE
//  Parametrised successor to the 4-digit button key checker.
//  Collects NUM_DIGITS entered digits, then compares them digit-serially against a key.
//  Two compare modes: early-exit (deliberately timing-leaky) or constant-time.
//  Adds an attempt limit, a lockout period and a compare-cycle counter for timing-attack experiments.
//  Sits between the debounced button receiver and the top-level LEDs/UART.
// PARAMETERS
//  NUM_DIGITS       4           digits per guess/key (>=1)
//  DIGIT_W          2           bits per digit (>=1)
//  CYCLES_PER_DIGIT 1           compare cycles spent per digit (>=1)
//  MAX_ATTEMPTS     3           consecutive fails before lockout (>=1)
//  LOCKOUT_CYCLES   50_000_000  clk cycles spent in lockout (>=1)
// PORTS
//  clk          in   1                    system clock, all logic on posedge
//  rst_n        in   1                    asynchronous, active-low reset
//  digit_valid  in   1                    1-cycle strobe: digit_in is a new entered digit
//  digit_in     in   DIGIT_W              entered digit value
//  key          in   NUM_DIGITS*DIGIT_W   correct key; digit k at [k*DIGIT_W +: DIGIT_W]; digit 0 entered first
//  const_time   in   1                    1 = constant-time compare, 0 = early exit
//  restart      in   1                    level; clears entry / leaves DONE
//  success      out  1                    level, high while in DONE
//  fail         out  1                    1-cycle pulse per failed guess
//  locked       out  1                    high while in LOCKOUT
//  in_receive   out  1                    state flag
//  in_compare   out  1                    state flag
//  in_done      out  1                    state flag
//  digit_count  out  $clog2(NUM_DIGITS+1) digits captured this attempt
//  fails_left   out  $clog2(MAX_ATTEMPTS+1) attempts remaining before lockout
//  cmp_cycles   out  16                   cycles spent in the last/current COMPARE, saturating
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - state RECEIVE, guess buffer 0, digit_count 0, fails_left=MAX_ATTEMPTS, cmp_cycles 0.
//   - success=fail=locked=0, in_receive=1, other flags 0.
//   - Applies immediately from any state, including mid-compare or lockout.
//  RECEIVE:
//   - digit_valid stores digit_in in slot digit_count; digit_count increments.
//   - On the strobe filling slot NUM_DIGITS-1: key and const_time are snapshotted on that
//     edge and the next state is COMPARE. digit_count holds at NUM_DIGITS.
//   - restart=1 clears the buffer and digit_count; restart wins over a same-cycle digit_valid.
//  Outside RECEIVE:
//   - digit_valid is ignored (no buffering).
//  COMPARE (T0 = first cycle with in_compare=1):
//   - Digit i occupies cycles T0+i*CPD .. T0+(i+1)*CPD-1 and is checked in its last cycle.
//     CPD = CYCLES_PER_DIGIT.
//   - Early exit (const_time snapshot 0): the first mismatch at digit i ends compare.
//     fail is high in cycle T0+(i+1)*CPD.
//   - Constant time: mismatches are OR-accumulated. The decision is always at digit NUM_DIGITS-1;
//     fail/success rises in cycle T0+NUM_DIGITS*CPD.
//   - All digits match: success rises in cycle T0+NUM_DIGITS*CPD, state DONE.
//   - cmp_cycles clears on entry, counts each COMPARE cycle, holds after exit,
//     saturates at 16'hFFFF.
//   - restart is ignored.
//  On fail:
//   - fails_left decrements; buffer and digit_count clear.
//   - If the new fails_left is 0, go to LOCKOUT; otherwise go to RECEIVE.
//  DONE:
//   - success=1. restart=1 moves to RECEIVE next cycle, clears the buffer and reloads fails_left.
//  LOCKOUT:
//   - locked=1; restart and digits are ignored.
//   - After exactly LOCKOUT_CYCLES cycles, return to RECEIVE with fails_left=MAX_ATTEMPTS.
//  Key changes after the snapshot do not affect the ongoing compare.
//  Exactly one of in_receive/in_compare/in_done/locked is high at any time.
// TESTING
//  Bench parameters: NUM_DIGITS=4, DIGIT_W=2, CPD=2, MAX_ATTEMPTS=3, LOCKOUT_CYCLES=10.
//  1. key=8'hE4, digits 0,1,2,3, const_time=0 -> success at T0+8, in_done=1, cmp_cycles=8.
//  2. key=8'hE4, digits 0,3,2,3, const_time=0 -> fail pulse at T0+4, cmp_cycles=4, fails_left=2.
//     Same guess with const_time=1 -> fail at T0+8, cmp_cycles=8.
//  3. Three wrong guesses -> locked=1 for 10 cycles; digits are ignored.
//     Then in_receive=1 and fails_left=3.
//  4. Two digits, then restart together with digit_valid -> digit_count=0.
//     A following correct 4-digit entry succeeds.
//  5. rst_n low during COMPARE -> all outputs take reset values immediately.
//     In DONE, restart -> in_receive=1 and fails_left=3.

Source files
------------

// File: rtl/key_checker_param.sv
// Digit-entry key checker: collects NUM_DIGITS digits, then compares them digit-serially
// (early-exit or constant-time), with an attempt limit, timed lockout and a compare-cycle counter.
module key_checker_param #(
  parameter int NUM_DIGITS       = 4,
  parameter int DIGIT_W          = 2,
  parameter int CYCLES_PER_DIGIT = 1,
  parameter int MAX_ATTEMPTS     = 3,
  parameter int LOCKOUT_CYCLES   = 50_000_000
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 digit_valid,
  input  logic [DIGIT_W-1:0]                   digit_in,
  input  logic [NUM_DIGITS*DIGIT_W-1:0]        key,
  input  logic                                 const_time,
  input  logic                                 restart,
  output logic                                 success,
  output logic                                 fail,
  output logic                                 locked,
  output logic                                 in_receive,
  output logic                                 in_compare,
  output logic                                 in_done,
  output logic [$clog2(NUM_DIGITS+1)-1:0]      digit_count,
  output logic [$clog2(MAX_ATTEMPTS+1)-1:0]    fails_left,
  output logic [15:0]                          cmp_cycles
);

  localparam int KW = NUM_DIGITS * DIGIT_W;
  localparam int CW = $clog2(NUM_DIGITS + 1);
  localparam int FW = $clog2(MAX_ATTEMPTS + 1);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PW = (CYCLES_PER_DIGIT > 1) ? $clog2(CYCLES_PER_DIGIT) : 1;
  localparam int LW = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;

  typedef enum logic [1:0] {S_RECEIVE, S_COMPARE, S_DONE, S_LOCKOUT} state_t;

  state_t             state_q, state_d;
  logic [KW-1:0]      guess_q;
  logic [KW-1:0]      key_snap;
  logic               ct_snap;
  logic [IW-1:0]      cmp_idx;
  logic [PW-1:0]      cmp_phase;
  logic               mis_acc;
  logic [LW-1:0]      lock_cnt;
  logic               fail_d;
  logic [DIGIT_W-1:0] guess_dig, key_dig;
  logic               digit_chk, last_digit, mis_now, mis_any;

  // Constant-index mux keeps the digit selection free of variable part-selects.
  always_comb begin
    guess_dig = '0;
    key_dig   = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (cmp_idx == IW'(i)) begin
        guess_dig = guess_q[i*DIGIT_W +: DIGIT_W];
        key_dig   = key_snap[i*DIGIT_W +: DIGIT_W];
      end
    end
  end

  assign digit_chk  = (cmp_phase == PW'(CYCLES_PER_DIGIT - 1));
  assign last_digit = (cmp_idx == IW'(NUM_DIGITS - 1));
  assign mis_now    = (guess_dig != key_dig);
  assign mis_any    = mis_acc | mis_now;

  always_comb begin
    state_d = state_q;
    fail_d  = 1'b0;
    case (state_q)
      S_RECEIVE: begin
        if (!restart && digit_valid && digit_count == CW'(NUM_DIGITS - 1))
          state_d = S_COMPARE;
      end
      S_COMPARE: begin
        if (digit_chk) begin
          if (mis_now && !ct_snap) begin
            fail_d = 1'b1;
          end else if (last_digit) begin
            if (mis_any) fail_d = 1'b1;
            else         state_d = S_DONE;
          end
          if (fail_d)
            state_d = (fails_left == FW'(1)) ? S_LOCKOUT : S_RECEIVE;
        end
      end
      S_DONE: begin
        if (restart) state_d = S_RECEIVE;
      end
      S_LOCKOUT: begin
        if (lock_cnt == LW'(LOCKOUT_CYCLES - 1)) state_d = S_RECEIVE;
      end
      default: state_d = S_RECEIVE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_RECEIVE;
      guess_q     <= '0;
      digit_count <= '0;
      fails_left  <= FW'(MAX_ATTEMPTS);
      cmp_cycles  <= '0;
      key_snap    <= '0;
      ct_snap     <= 1'b0;
      cmp_idx     <= '0;
      cmp_phase   <= '0;
      mis_acc     <= 1'b0;
      lock_cnt    <= '0;
      fail        <= 1'b0;
    end else begin
      state_q <= state_d;
      fail    <= fail_d;
      case (state_q)
        S_RECEIVE: begin
          if (restart) begin
            guess_q     <= '0;
            digit_count <= '0;
          end else if (digit_valid) begin
            for (int i = 0; i < NUM_DIGITS; i++)
              if (digit_count == CW'(i)) guess_q[i*DIGIT_W +: DIGIT_W] <= digit_in;
            digit_count <= digit_count + CW'(1);
          end
          // Key and mode are frozen here so later key changes cannot steer the compare.
          if (state_d == S_COMPARE) begin
            key_snap   <= key;
            ct_snap    <= const_time;
            cmp_cycles <= '0;
            cmp_idx    <= '0;
            cmp_phase  <= '0;
            mis_acc    <= 1'b0;
          end
        end
        S_COMPARE: begin
          if (cmp_cycles != 16'hFFFF) cmp_cycles <= cmp_cycles + 16'd1;
          if (digit_chk) begin
            cmp_phase <= '0;
            mis_acc   <= mis_any;
            if (!last_digit) cmp_idx <= cmp_idx + IW'(1);
          end else begin
            cmp_phase <= cmp_phase + PW'(1);
          end
          if (fail_d) begin
            fails_left  <= fails_left - FW'(1);
            guess_q     <= '0;
            digit_count <= '0;
            lock_cnt    <= '0;
          end
        end
        S_DONE: begin
          if (restart) begin
            guess_q     <= '0;
            digit_count <= '0;
            fails_left  <= FW'(MAX_ATTEMPTS);
          end
        end
        S_LOCKOUT: begin
          lock_cnt <= lock_cnt + LW'(1);
          if (state_d == S_RECEIVE) fails_left <= FW'(MAX_ATTEMPTS);
        end
        default: ;
      endcase
    end
  end

  assign in_receive = (state_q == S_RECEIVE);
  assign in_compare = (state_q == S_COMPARE);
  assign in_done    = (state_q == S_DONE);
  assign locked     = (state_q == S_LOCKOUT);
  assign success    = in_done;

endmodule

// File: tb/tb_key_checker_param.sv
// Randomized bench for key_checker_param against a transaction-level model of the checker.
module tb_key_checker_param;

  localparam int ND  = 4;
  localparam int DW  = 2;
  localparam int CPD = 2;
  localparam int MA  = 3;
  localparam int LC  = 10;
  localparam int KW  = ND * DW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          digit_valid;
  logic [DW-1:0] digit_in;
  logic [KW-1:0] key;
  logic          const_time;
  logic          restart;
  logic          success, fail, locked, in_receive, in_compare, in_done;
  logic [2:0]    digit_count;
  logic [1:0]    fails_left;
  logic [15:0]   cmp_cycles;

  int n_checks = 0;
  int n_errors = 0;
  int m_fails_left = MA;

  key_checker_param #(
    .NUM_DIGITS(ND), .DIGIT_W(DW), .CYCLES_PER_DIGIT(CPD),
    .MAX_ATTEMPTS(MA), .LOCKOUT_CYCLES(LC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .digit_valid(digit_valid), .digit_in(digit_in),
    .key(key), .const_time(const_time), .restart(restart),
    .success(success), .fail(fail), .locked(locked),
    .in_receive(in_receive), .in_compare(in_compare), .in_done(in_done),
    .digit_count(digit_count), .fails_left(fails_left), .cmp_cycles(cmp_cycles)
  );

  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic enter_digits(input logic [KW-1:0] g, input int n);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 2)) tick;
      digit_in    = g[i*DW +: DW];
      digit_valid = 1'b1;
      tick;
      digit_valid = 1'b0;
      chk("digit_count_entry", digit_count, i + 1);
    end
  endtask

  // Drives a complete guess and checks the attempt outcome from first principles.
  task automatic attempt(input logic [KW-1:0] g, input logic [KW-1:0] k, input logic ct);
    int  first_mis = ND;
    int  exp_len;
    int  cnt = 0;
    bit  ok;
    key        = k;
    const_time = ct;
    enter_digits(g, ND);
    for (int i = ND - 1; i >= 0; i--)
      if (g[i*DW +: DW] != k[i*DW +: DW]) first_mis = i;
    ok      = (first_mis == ND);
    exp_len = (ok || ct) ? ND * CPD : (first_mis + 1) * CPD;
    while (in_compare === 1'b1 && cnt < 100) begin
      cnt++;
      key         = KW'($urandom);
      restart     = 1'($urandom_range(0, 1));
      digit_valid = 1'($urandom_range(0, 1));
      digit_in    = DW'($urandom);
      tick;
    end
    restart     = 1'b0;
    digit_valid = 1'b0;
    chk("compare_len", cnt, exp_len);
    chk("cmp_cycles", cmp_cycles, exp_len);
    chk("one_hot", $countones({in_receive, in_compare, in_done, locked}), 1);
    if (ok) begin
      chk("success", success, 1);
      chk("in_done", in_done, 1);
      chk("fail_on_success", fail, 0);
      chk("fails_left_success", fails_left, m_fails_left);
    end else begin
      m_fails_left--;
      chk("fail_pulse", fail, 1);
      chk("success_on_fail", success, 0);
      chk("fails_left_fail", fails_left, m_fails_left);
      chk("locked_after_fail", locked, m_fails_left == 0);
      chk("digit_count_cleared", digit_count, 0);
    end
    tick;
    chk("fail_one_cycle", fail, 0);
    if (!ok && m_fails_left == 0) begin
      cnt = 1;
      while (locked === 1'b1 && cnt < 100) begin
        cnt++;
        restart     = 1'($urandom_range(0, 1));
        digit_valid = 1'($urandom_range(0, 1));
        digit_in    = DW'($urandom);
        tick;
      end
      restart     = 1'b0;
      digit_valid = 1'b0;
      m_fails_left = MA;
      chk("lockout_len", cnt, LC);
      chk("receive_after_lock", in_receive, 1);
      chk("fails_left_after_lock", fails_left, MA);
      chk("digit_count_after_lock", digit_count, 0);
    end
  endtask

  task automatic leave_done;
    restart = 1'b1;
    tick;
    restart = 1'b0;
    m_fails_left = MA;
    chk("restart_in_receive", in_receive, 1);
    chk("restart_success_low", success, 0);
    chk("restart_fails_left", fails_left, MA);
    chk("restart_digit_count", digit_count, 0);
  endtask

  task automatic partial_restart(input int n, input logic with_digit);
    enter_digits(KW'($urandom), n);
    restart     = 1'b1;
    digit_valid = with_digit;
    digit_in    = DW'($urandom);
    tick;
    restart     = 1'b0;
    digit_valid = 1'b0;
    chk("partial_restart_count", digit_count, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_success"}, success, 0);
    chk({tag, "_fail"}, fail, 0);
    chk({tag, "_locked"}, locked, 0);
    chk({tag, "_in_receive"}, in_receive, 1);
    chk({tag, "_in_compare"}, in_compare, 0);
    chk({tag, "_in_done"}, in_done, 0);
    chk({tag, "_digit_count"}, digit_count, 0);
    chk({tag, "_fails_left"}, fails_left, MA);
    chk({tag, "_cmp_cycles"}, cmp_cycles, 0);
  endtask

  initial begin
    logic [KW-1:0] k, g;
    logic          ct;
    rst_n       = 1'b0;
    digit_valid = 1'b0;
    digit_in    = '0;
    key         = '0;
    const_time  = 1'b0;
    restart     = 1'b0;
    repeat (3) tick;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    tick;

    // Directed cases around key E4 (digits 0,1,2,3).
    attempt(8'hE4, 8'hE4, 1'b0);
    leave_done;
    attempt(8'hEC, 8'hE4, 1'b0);
    attempt(8'hEC, 8'hE4, 1'b1);
    attempt(8'h00, 8'hE4, 1'b1);
    partial_restart(2, 1'b1);
    attempt(8'hE4, 8'hE4, 1'b1);
    leave_done;

    // Asynchronous reset in the middle of a compare.
    attempt(8'hE5, 8'hE4, 1'b0);
    key = 8'hE4;
    enter_digits(8'hE4, ND);
    tick;
    tick;
    chk("pre_reset_in_compare", in_compare, 1);
    rst_n = 1'b0;
    #2;
    check_reset_outputs("async_reset");
    m_fails_left = MA;
    @(negedge clk);
    rst_n = 1'b1;
    tick;

    // Randomized guesses against random keys.
    for (int it = 0; it < 60; it++) begin
      k  = KW'($urandom);
      ct = 1'($urandom_range(0, 1));
      g  = k;
      if ($urandom_range(0, 2) != 0) begin
        int j = $urandom_range(0, ND - 1);
        g[j*DW +: DW] = g[j*DW +: DW] ^ DW'($urandom_range(1, 3));
        if ($urandom_range(0, 1) == 1) g = g ^ KW'($urandom);
      end
      if ($urandom_range(0, 3) == 0)
        partial_restart($urandom_range(1, ND - 1), 1'($urandom_range(0, 1)));
      attempt(g, k, ct);
      if (in_done === 1'b1) leave_done;
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
